// File: rtl/clk_div_scheduler.sv
// Power-of-two clock divider with a handshaked ratio-change request that is applied
// only at the counter wrap, so the divided output never glitches.
module clk_div_scheduler #(
   parameter int unsigned TCNT_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic              cfg_valid_i,
   input  logic [1:0]        cfg_sel_i,
   output logic              cfg_ready_o,
   output logic [1:0]        active_sel_o,
   output logic              div_out_o,
   output logic              tick_o,
   output logic              switch_done_o,
   output logic              busy_o,
   output logic [TCNT_W-1:0] tick_cnt_o
);

   typedef enum logic [1:0] {StIdle, StRun, StPend} state_e;

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [1:0]        active_sel_q, active_sel_d;
   logic [1:0]        pend_sel_q, pend_sel_d;
   logic [TCNT_W-1:0] tick_cnt_q, tick_cnt_d;
   logic              switch_done_q;
   logic              load;
   logic              accept;
   logic              cnt_wrap;
   logic              tick;
   logic [3:0]        tick_mask;

   assign cfg_ready_o = (state_q != StPend);
   assign busy_o      = (state_q == StPend);
   assign accept      = cfg_valid_i & cfg_ready_o;
   assign cnt_wrap    = (cnt_q == 4'hF);

   always_comb begin
      tick_mask = 4'h1;
      unique case (active_sel_q)
         2'd0: tick_mask = 4'h1;
         2'd1: tick_mask = 4'h3;
         2'd2: tick_mask = 4'h7;
         2'd3: tick_mask = 4'hF;
         default: tick_mask = 4'h1;
      endcase
   end

   assign tick = en_i & ((cnt_q & tick_mask) == tick_mask);

   always_comb begin
      state_d      = state_q;
      active_sel_d = active_sel_q;
      pend_sel_d   = pend_sel_q;
      load         = 1'b0;
      cnt_d        = en_i ? cnt_q + 4'd1 : 4'd0;
      tick_cnt_d   = (tick && (tick_cnt_q != '1)) ? tick_cnt_q + 1'b1 : tick_cnt_q;

      if (accept) begin
         pend_sel_d = cfg_sel_i;
      end

      unique case (state_q)
         StIdle: begin
            // cnt is 0 here, so an immediate load cannot glitch div_out
            if (accept) begin
               active_sel_d = cfg_sel_i;
               load         = 1'b1;
            end
            if (en_i) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (!en_i) begin
               state_d = StIdle;
               // counter is being cleared on this edge, so apply right away
               if (accept) begin
                  active_sel_d = cfg_sel_i;
                  load         = 1'b1;
               end
            end else if (accept) begin
               state_d = StPend;
            end
         end
         StPend: begin
            if (!en_i) begin
               active_sel_d = pend_sel_q;
               load         = 1'b1;
               state_d      = StIdle;
            end else if (cnt_wrap) begin
               active_sel_d = pend_sel_q;
               load         = 1'b1;
               state_d      = StRun;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= StIdle;
         cnt_q         <= 4'd0;
         active_sel_q  <= 2'd0;
         pend_sel_q    <= 2'd0;
         tick_cnt_q    <= '0;
         switch_done_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         active_sel_q  <= active_sel_d;
         pend_sel_q    <= pend_sel_d;
         tick_cnt_q    <= tick_cnt_d;
         switch_done_q <= load;
      end
   end

   assign active_sel_o  = active_sel_q;
   assign div_out_o     = cnt_q[active_sel_q];
   assign tick_o        = tick;
   assign switch_done_o = switch_done_q;
   assign tick_cnt_o    = tick_cnt_q;

endmodule
